// File: rtl/ts_link_pkg.sv
// Shared definitions for the TS GTX link (transmit framer and receive deframer).
// Holds the K-code bytes, the CRC-16/CCITT-FALSE constants, the frame FSM
// state encoding and the one-word CRC update function.
package ts_link_pkg;

  // K-characters carried in the low byte of a K-flagged word
  localparam logic [7:0] K_COMMA = 8'hBC;  // K28.5, idle / alignment
  localparam logic [7:0] K_SOF   = 8'h3C;  // K28.1, start of frame
  localparam logic [7:0] K_EOF   = 8'h5C;  // K28.2, end of frame

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Frame FSM encoding: IDLE -> SOF -> PAY -> CRC -> EOF -> IDLE
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_SOF  = 3'd1;
  localparam logic [ST_W-1:0] ST_PAY  = 3'd2;
  localparam logic [ST_W-1:0] ST_CRC  = 3'd3;
  localparam logic [ST_W-1:0] ST_EOF  = 3'd4;

  // Fold one 16-bit word into the CRC, MSB first, no reflection
  function automatic logic [15:0] crc16_next(input logic [15:0] crc_in,
                                             input logic [15:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/ts_crc16.sv
// CRC-16/CCITT-FALSE accumulator, one 16-bit word per clock.
// Ports:
//   clk, reset_soft : clock and synchronous active-high reset
//   init            : restart from CRC_INIT
//   en              : fold data into the CRC this cycle
//   data            : word to fold in
//   crc             : registered CRC value
// With init and en together the word is folded into a fresh CRC_INIT, so the
// first word of a frame can be absorbed in the same cycle the CRC is seeded.
module ts_crc16
  import ts_link_pkg::*;
(
  input  logic        clk,
  input  logic        reset_soft,
  input  logic        init,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] crc
);

  logic [15:0] crc_next_c;

  assign crc_next_c = crc16_next(init ? CRC_INIT : crc, data);

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset_soft) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next_c;
    end else if (init) begin
      crc <= CRC_INIT;
    end
  end

endmodule

// File: rtl/ts_tx_framer.sv
// Transmit framer for the trigger-scintillator GTX link.
// Emits comma idles {idle_cnt, BC} between frames and frames as
// SOF {seq,3C}, NWORDS payload words, CRC-16, EOF {frames_sent[7:0],5C}.
// Ports:
//   tx_clk       : txusrclk2, the only clock
//   reset_soft   : synchronous active-high reset, aborts a frame in flight
//   enable       : allow new frames to start
//   frame_data   : NWORDS x 16-bit payload, word 0 in the low bits, sent first
//   frame_valid  : frame_data is valid
//   frame_ready  : frame accepted this cycle if frame_valid is high
//   tx_d, tx_k   : GTX txdata / txcharisk (tx_k[0] qualifies tx_d[7:0])
//   busy         : SOF..EOF in flight
//   frames_sent  : completed EOF count, wraps
// All outputs are registered: the next-cycle value is computed alongside the
// next state, so each word appears exactly in the cycle its state is active.
module ts_tx_framer
  import ts_link_pkg::*;
#(
  parameter int unsigned NWORDS   = 8,
  parameter int unsigned IDLE_MIN = 4
) (
  input  logic                  tx_clk,
  input  logic                  reset_soft,
  input  logic                  enable,
  input  logic [16*NWORDS-1:0]  frame_data,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic [15:0]           tx_d,
  output logic [1:0]            tx_k,
  output logic                  busy,
  output logic [15:0]           frames_sent
);

  localparam int unsigned DW  = 16 * NWORDS;
  localparam int unsigned WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);
  localparam logic [7:0]     GAP_FULL  = 8'(IDLE_MIN);

  logic [ST_W-1:0] state,       state_nxt;
  logic [DW-1:0]   pay_buf,     pay_buf_nxt;
  logic [WCW-1:0]  word_cnt,    word_cnt_nxt;
  logic [7:0]      seq,         seq_nxt;
  logic [7:0]      idle_cnt,    idle_cnt_nxt;
  logic [7:0]      gap_cnt,     gap_cnt_nxt;
  logic            frame_ready_nxt;
  logic [15:0]     tx_d_nxt;
  logic [1:0]      tx_k_nxt;
  logic            busy_nxt;
  logic [15:0]     frames_sent_nxt;

  logic            accept_c;
  logic            crc_init_c;
  logic            crc_en_c;
  logic [15:0]     crc_q;

  assign accept_c = frame_valid && frame_ready;

  // CRC absorbs each payload word as it is loaded into tx_d, so after the
  // last word is on the line crc_q already holds the frame CRC.
  ts_crc16 u_crc (
    .clk        (tx_clk),
    .reset_soft (reset_soft),
    .init       (crc_init_c),
    .en         (crc_en_c),
    .data       (pay_buf[15:0]),
    .crc        (crc_q)
  );

  // Next state and next registered outputs
  always_comb begin
    state_nxt       = state;
    pay_buf_nxt     = pay_buf;
    word_cnt_nxt    = word_cnt;
    seq_nxt         = seq;
    idle_cnt_nxt    = idle_cnt;
    gap_cnt_nxt     = gap_cnt;
    frames_sent_nxt = frames_sent;
    tx_d_nxt        = tx_d;
    tx_k_nxt        = tx_k;
    crc_init_c      = 1'b0;
    crc_en_c        = 1'b0;

    case (state)
      ST_IDLE: begin
        idle_cnt_nxt = idle_cnt + 8'd1;
        if (gap_cnt != GAP_FULL) gap_cnt_nxt = gap_cnt + 8'd1;
        tx_k_nxt = 2'b01;
        if (accept_c) begin
          state_nxt   = ST_SOF;
          pay_buf_nxt = frame_data;
          tx_d_nxt    = {seq, K_SOF};
        end else begin
          tx_d_nxt    = {idle_cnt + 8'd1, K_COMMA};
        end
      end
      ST_SOF: begin
        crc_init_c   = 1'b1;
        crc_en_c     = 1'b1;
        state_nxt    = ST_PAY;
        word_cnt_nxt = '0;
        tx_d_nxt     = pay_buf[15:0];
        tx_k_nxt     = 2'b00;
        pay_buf_nxt  = pay_buf >> 16;
      end
      ST_PAY: begin
        tx_k_nxt = 2'b00;
        if (word_cnt == LAST_WORD) begin
          state_nxt = ST_CRC;
          tx_d_nxt  = crc_q;
        end else begin
          crc_en_c     = 1'b1;
          word_cnt_nxt = word_cnt + WCW'(1);
          tx_d_nxt     = pay_buf[15:0];
          pay_buf_nxt  = pay_buf >> 16;
        end
      end
      ST_CRC: begin
        state_nxt = ST_EOF;
        tx_d_nxt  = {frames_sent[7:0], K_EOF};
        tx_k_nxt  = 2'b01;
      end
      ST_EOF: begin
        state_nxt       = ST_IDLE;
        frames_sent_nxt = frames_sent + 16'd1;
        seq_nxt         = seq + 8'd1;
        gap_cnt_nxt     = 8'd0;
        tx_d_nxt        = {idle_cnt, K_COMMA};
        tx_k_nxt        = 2'b01;
      end
      default: begin
        state_nxt = ST_IDLE;
        tx_d_nxt  = {idle_cnt, K_COMMA};
        tx_k_nxt  = 2'b01;
      end
    endcase

    busy_nxt        = (state_nxt != ST_IDLE);
    frame_ready_nxt = (state_nxt == ST_IDLE) && enable && (gap_cnt_nxt == GAP_FULL);
  end

  // State and output registers
  always_ff @(posedge tx_clk) begin
    if (reset_soft) begin
      state       <= ST_IDLE;
      pay_buf     <= '0;
      word_cnt    <= '0;
      seq         <= 8'd0;
      idle_cnt    <= 8'd0;
      gap_cnt     <= 8'd0;
      frame_ready <= 1'b0;
      tx_d        <= {8'h00, K_COMMA};
      tx_k        <= 2'b01;
      busy        <= 1'b0;
      frames_sent <= 16'd0;
    end else begin
      state       <= state_nxt;
      pay_buf     <= pay_buf_nxt;
      word_cnt    <= word_cnt_nxt;
      seq         <= seq_nxt;
      idle_cnt    <= idle_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      frame_ready <= frame_ready_nxt;
      tx_d        <= tx_d_nxt;
      tx_k        <= tx_k_nxt;
      busy        <= busy_nxt;
      frames_sent <= frames_sent_nxt;
    end
  end

endmodule

// File: tb/tb_ts_tx_framer.sv
// Directed bench for ts_tx_framer (NWORDS = 8, IDLE_MIN = 4).
`timescale 1ns/1ps
module tb_ts_tx_framer;

  localparam int unsigned NW = 8;
  localparam int unsigned IM = 4;

  logic             tx_clk = 1'b0;
  logic             reset_soft;
  logic             enable;
  logic [16*NW-1:0] frame_data;
  logic             frame_valid;
  logic             frame_ready;
  logic [15:0]      tx_d;
  logic [1:0]       tx_k;
  logic             busy;
  logic [15:0]      frames_sent;

  int n_checks = 0;
  int n_fail   = 0;

  ts_tx_framer #(.NWORDS(NW), .IDLE_MIN(IM)) dut (
    .tx_clk      (tx_clk),
    .reset_soft  (reset_soft),
    .enable      (enable),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .tx_d        (tx_d),
    .tx_k        (tx_k),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic step();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (frame_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Byte-serial reference CRC-16/CCITT-FALSE over the payload words
  function automatic logic [15:0] ref_crc(input logic [16*NW-1:0] d);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int w = 0; w < int'(NW); w++) begin
      for (int h = 1; h >= 0; h--) begin
        b = d[16*w + 8*h +: 8];
        c = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++)
          c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  task automatic test_reset();
    reset_soft  = 1'b1;
    enable      = 1'b1;
    frame_valid = 1'b0;
    frame_data  = '0;
    step();
    step();
    n_checks++;
    if (tx_d !== 16'h00BC || tx_k !== 2'b01) begin
      n_fail++; $display("FAIL reset_tx: got %h/%b expected 00bc/01", tx_d, tx_k);
    end
    n_checks++;
    if (frame_ready !== 1'b0 || busy !== 1'b0 || frames_sent !== 16'd0) begin
      n_fail++; $display("FAIL reset_flags: got ready=%b busy=%b fs=%0d expected 0/0/0",
                         frame_ready, busy, frames_sent);
    end
    reset_soft = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (tx_d !== {8'(k), 8'hBC} || tx_k !== 2'b01) begin
        n_fail++; $display("FAIL idle_word[%0d]: got %h/%b expected %h/01", k, tx_d, tx_k, {8'(k), 8'hBC});
      end
      n_checks++;
      if (frame_ready !== (k >= 4)) begin
        n_fail++; $display("FAIL idle_ready[%0d]: got %b expected %b", k, frame_ready, (k >= 4));
      end
      step();
    end
  endtask

  task automatic test_single_frame();
    logic [16*NW-1:0] d;
    bit ok;
    for (int i = 0; i < int'(NW); i++) d[16*i +: 16] = 16'(i + 1);
    frame_data  = d;
    frame_valid = 1'b1;
    wait_ready(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_ready: got timeout expected ready"); end
    step();
    frame_valid = 1'b0;
    frame_data  = ~d;
    n_checks++;
    if (tx_d !== 16'h003C || tx_k !== 2'b01 || busy !== 1'b1 || frame_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_sof: got %h/%b busy=%b ready=%b expected 003c/01 1 0",
                         tx_d, tx_k, busy, frame_ready);
    end
    for (int i = 0; i < int'(NW); i++) begin
      step();
      n_checks++;
      if (tx_d !== 16'(i + 1) || tx_k !== 2'b00) begin
        n_fail++; $display("FAIL single_pay[%0d]: got %h/%b expected %h/00", i, tx_d, tx_k, 16'(i + 1));
      end
    end
    step();
    n_checks++;
    if (tx_d !== ref_crc(d) || tx_k !== 2'b00) begin
      n_fail++; $display("FAIL single_crc: got %h/%b expected %h/00", tx_d, tx_k, ref_crc(d));
    end
    step();
    n_checks++;
    if (tx_d !== 16'h005C || tx_k !== 2'b01) begin
      n_fail++; $display("FAIL single_eof: got %h/%b expected 005c/01", tx_d, tx_k);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || frames_sent !== 16'd1 || tx_k !== 2'b01 || tx_d[7:0] !== 8'hBC) begin
      n_fail++; $display("FAIL single_done: got busy=%b fs=%0d %h/%b expected 0 1 xxbc/01",
                         busy, frames_sent, tx_d, tx_k);
    end
  endtask

  task automatic test_bcbc_payload();
    logic [16*NW-1:0] d;
    logic [15:0] words [NW];
    logic [15:0] got [NW+1];
    int sof_n, eof_n, err_n, data_n;
    bit ok;
    words = '{16'hBCBC, 16'h00BC, 16'hBC00, 16'h3C5C, 16'h5C3C, 16'hBCBC, 16'h1234, 16'hBCBC};
    for (int i = 0; i < int'(NW); i++) d[16*i +: 16] = words[i];
    sof_n = 0; eof_n = 0; err_n = 0; data_n = 0;
    frame_data  = d;
    frame_valid = 1'b1;
    wait_ready(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bcbc_ready: got timeout expected ready"); end
    step();
    frame_valid = 1'b0;
    n_checks++;
    if (tx_d !== 16'h013C) begin
      n_fail++; $display("FAIL bcbc_sof_seq: got %h expected 013c", tx_d);
    end
    // Loopback receiver: classify every word from SOF to the first idle
    for (int c = 0; c < 12; c++) begin
      if (c == 10) begin
        n_checks++;
        if (tx_d !== 16'h015C || tx_k !== 2'b01) begin
          n_fail++; $display("FAIL bcbc_eof: got %h/%b expected 015c/01", tx_d, tx_k);
        end
      end
      if (tx_k === 2'b01) begin
        if (tx_d[7:0] === 8'h3C) sof_n++;
        else if (tx_d[7:0] === 8'h5C) eof_n++;
        else if (tx_d[7:0] !== 8'hBC) err_n++;
      end else if (tx_k === 2'b00) begin
        if (data_n < int'(NW) + 1) got[data_n] = tx_d;
        data_n++;
      end else begin
        err_n++;
      end
      step();
    end
    n_checks++;
    if (sof_n != 1 || eof_n != 1 || err_n != 0 || data_n != int'(NW) + 1) begin
      n_fail++; $display("FAIL bcbc_rx: got sof=%0d eof=%0d err=%0d data=%0d expected 1 1 0 %0d",
                         sof_n, eof_n, err_n, data_n, NW + 1);
    end
    for (int i = 0; i < int'(NW); i++) begin
      n_checks++;
      if (got[i] !== words[i]) begin
        n_fail++; $display("FAIL bcbc_pay[%0d]: got %h expected %h", i, got[i], words[i]);
      end
    end
    n_checks++;
    if (got[NW] !== ref_crc(d)) begin
      n_fail++; $display("FAIL bcbc_crc: got %h expected %h", got[NW], ref_crc(d));
    end
    n_checks++;
    if (frames_sent !== 16'd2) begin
      n_fail++; $display("FAIL bcbc_count: got %0d expected 2", frames_sent);
    end
  endtask

  task automatic test_enable_drop();
    logic [16*NW-1:0] d;
    int bad;
    bit ok;
    for (int i = 0; i < int'(NW); i++) d[16*i +: 16] = 16'hA000 + 16'(i);
    bad = 0;
    frame_data  = d;
    frame_valid = 1'b1;
    wait_ready(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL en_ready: got timeout expected ready"); end
    step();
    n_checks++;
    if (tx_d !== 16'h023C) begin
      n_fail++; $display("FAIL en_sof: got %h expected 023c", tx_d);
    end
    step();
    step();
    enable = 1'b0;
    for (int i = 0; i < 8; i++) step();
    n_checks++;
    if (tx_d !== 16'h025C || tx_k !== 2'b01) begin
      n_fail++; $display("FAIL en_eof: got %h/%b expected 025c/01", tx_d, tx_k);
    end
    // frame_valid stays high upstream while enable is low
    for (int i = 0; i < 12; i++) begin
      step();
      if (frame_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL en_hold: got %0d cycles ready/busy expected 0", bad);
    end
    n_checks++;
    if (frames_sent !== 16'd3) begin
      n_fail++; $display("FAIL en_count: got %0d expected 3", frames_sent);
    end
    enable = 1'b1;
    step();
    n_checks++;
    if (frame_ready !== 1'b1) begin
      n_fail++; $display("FAIL en_return_ready: got %b expected 1", frame_ready);
    end
    step();
    frame_valid = 1'b0;
    n_checks++;
    if (tx_d !== 16'h033C || tx_k !== 2'b01) begin
      n_fail++; $display("FAIL en_next_sof: got %h/%b expected 033c/01", tx_d, tx_k);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || frames_sent !== 16'd4) begin
      n_fail++; $display("FAIL en_final_count: got %0d (idle=%b) expected 4", frames_sent, ok);
    end
  endtask

  task automatic test_reset_abort();
    logic [16*NW-1:0] d;
    bit ok;
    for (int i = 0; i < int'(NW); i++) d[16*i +: 16] = 16'h5A00 + 16'(i);
    reset_soft = 1'b1;
    step();
    reset_soft  = 1'b0;
    frame_data  = d;
    frame_valid = 1'b1;
    wait_ready(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL abort_ready: got timeout expected ready"); end
    step();
    frame_valid = 1'b0;
    n_checks++;
    if (tx_d !== 16'h003C) begin
      n_fail++; $display("FAIL abort_sof: got %h expected 003c", tx_d);
    end
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (tx_d !== 16'h5A03 || tx_k !== 2'b00) begin
      n_fail++; $display("FAIL abort_word3: got %h/%b expected 5a03/00", tx_d, tx_k);
    end
    reset_soft = 1'b1;
    step();
    reset_soft = 1'b0;
    n_checks++;
    if (tx_d !== 16'h00BC || tx_k !== 2'b01 || busy !== 1'b0 || frames_sent !== 16'd0) begin
      n_fail++; $display("FAIL abort_idle: got %h/%b busy=%b fs=%0d expected 00bc/01 0 0",
                         tx_d, tx_k, busy, frames_sent);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (tx_d !== {8'(k), 8'hBC} || tx_k !== 2'b01 || frame_ready !== (k >= 4)) begin
        n_fail++; $display("FAIL abort_gap[%0d]: got %h/%b ready=%b expected %h/01 ready=%b",
                           k, tx_d, tx_k, frame_ready, {8'(k), 8'hBC}, (k >= 4));
      end
      if (k < 4) step();
    end
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    n_checks++;
    if (tx_d !== 16'h003C || tx_k !== 2'b01) begin
      n_fail++; $display("FAIL abort_resume_sof: got %h/%b expected 003c/01", tx_d, tx_k);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || frames_sent !== 16'd1) begin
      n_fail++; $display("FAIL abort_resume_count: got %0d (idle=%b) expected 1", frames_sent, ok);
    end
  endtask

  task automatic test_back_to_back();
    int sof_n, last_c, c;
    bit ok;
    sof_n = 0; last_c = 0; c = 0;
    reset_soft = 1'b1;
    step();
    reset_soft = 1'b0;
    for (int i = 0; i < int'(NW); i++) frame_data[16*i +: 16] = 16'hC0DE ^ 16'(i);
    frame_valid = 1'b1;
    while (sof_n < 300 && c < 300 * 16 + 100) begin
      if (tx_k === 2'b01 && tx_d[7:0] === 8'h3C) begin
        n_checks++;
        if (tx_d[15:8] !== 8'(sof_n)) begin
          n_fail++; $display("FAIL b2b_seq[%0d]: got %h expected %h", sof_n, tx_d[15:8], 8'(sof_n));
        end
        if (sof_n > 0) begin
          n_checks++;
          if (c - last_c != 16) begin
            n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 16", sof_n, c - last_c);
          end
        end
        last_c = c;
        sof_n++;
      end
      if (sof_n < 300) begin
        step();
        c++;
      end
    end
    frame_valid = 1'b0;
    n_checks++;
    if (sof_n != 300) begin
      n_fail++; $display("FAIL b2b_frames: got %0d SOFs expected 300", sof_n);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || frames_sent !== 16'd300) begin
      n_fail++; $display("FAIL b2b_count: got %0d (idle=%b) expected 300", frames_sent, ok);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bcbc_payload();
    test_enable_drop();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within 1 ms");
    $fatal(1);
  end

endmodule
